// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding and the
// constant clog2 used to size the iteration counter.
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/nbit_adder.sv
// Parametrised ripple-carry adder with carry-in and carry-out.
module nbit_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    always_comb begin
        logic carry;
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/nbit_seq_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Define SIGNED_MODE_EN to add the is_signed port and two's-complement support.
module nbit_seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MODE_EN
    input  logic               is_signed,
`endif
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned CntW = clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e               state_q;
    logic [WIDTH-1:0]     mcand_q, mplier_q;
    // Partial sums never reach bit 2*WIDTH-1; the adder carry-out supplies it.
    logic [2*WIDTH-2:0]   acc_q;
    logic [CntW-1:0]      cnt_q;
    logic [2*WIDTH-1:0]   p_q;
    logic                 ready_q, busy_q, done_q;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-2:0]   addend, sum_lo;
    logic                 sum_c;
    logic [2*WIDTH-1:0]   prod, p_next;

    always_comb begin
        addend = '0;
        if (mplier_q[0]) begin
            addend = {{(WIDTH-1){1'b0}}, mcand_q} << cnt_q;
        end
    end

    nbit_adder #(.WIDTH(2*WIDTH-1)) u_acc_add (
        .a_i   (acc_q),
        .b_i   (addend),
        .cin_i (1'b0),
        .sum_o (sum_lo),
        .cout_o(sum_c)
    );

    assign prod = {sum_c, sum_lo};

`ifdef SIGNED_MODE_EN
    logic               neg_q, neg_d;
    logic [2*WIDTH-2:0] neg_lo;
    logic               neg_c;

    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        neg_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    // Negation as invert + 1; the top bit takes the carry out of the lower bits.
    nbit_adder #(.WIDTH(2*WIDTH-1)) u_neg_add (
        .a_i   (~prod[2*WIDTH-2:0]),
        .b_i   ('0),
        .cin_i (1'b1),
        .sum_o (neg_lo),
        .cout_o(neg_c)
    );

    assign p_next = neg_q ? {~prod[2*WIDTH-1] ^ neg_c, neg_lo} : prod;
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign p_next = prod;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
`ifdef SIGNED_MODE_EN
                        neg_q    <= neg_d;
`endif
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= StRun;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                StRun: begin
                    acc_q    <= sum_lo;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == CntLast) begin
                        p_q     <= p_next;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign p     = p_q;

endmodule

// File: tb/tb_nbit_seq_multiplier.sv
// Self-checking bench: a WIDTH=8 and a WIDTH=3 instance against arithmetic reference products.
module tb_nbit_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, busy8, done8;
    logic [15:0] p8;

    logic        start3 = 1'b0, sgn3 = 1'b0;
    logic [2:0]  a3 = '0, b3 = '0;
    logic        ready3, busy3, done3;
    logic [5:0]  p3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nbit_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .a        (a8),
        .b        (b8),
`ifdef SIGNED_MODE_EN
        .is_signed(sgn8),
`endif
        .ready    (ready8),
        .busy     (busy8),
        .done     (done8),
        .p        (p8)
    );

    nbit_seq_multiplier #(.WIDTH(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .start    (start3),
        .a        (a3),
        .b        (b3),
`ifdef SIGNED_MODE_EN
        .is_signed(sgn3),
`endif
        .ready    (ready3),
        .busy     (busy3),
        .done     (done3),
        .p        (p3)
    );

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                         input logic s);
        int sx, sy, r;
        sx = int'(x);
        sy = int'(y);
        if (s && x[7]) sx = sx - 256;
        if (s && y[7]) sy = sy - 256;
        r = sx * sy;
        return r[15:0];
    endfunction

    // Call at a negedge; start is accepted on the next posedge. Ends at the negedge after
    // the DONE->IDLE edge, so a following call starts at the earliest legal edge.
    task automatic mul8(input logic [7:0] ai, input logic [7:0] bi, input logic si,
                        output logic [15:0] prod, output int lat);
        a8 = ai; b8 = bi; sgn8 = si; start8 = 1'b1;
        @(posedge clk); @(negedge clk);
        start8 = 1'b0;
        lat = -1;
        prod = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (done8) begin
                lat = n;
                break;
            end
        end
        prod = p8;
        if (lat > 0) begin
            checks++;
            if (ready8 !== 1'b0 || busy8 !== 1'b1) begin
                failures++;
                $display("FAIL mul8_done_state: ready=%b busy=%b want ready=0 busy=1", ready8, busy8);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (done8 !== 1'b0 || ready8 !== 1'b1 || busy8 !== 1'b0 || p8 !== prod) begin
                failures++;
                $display("FAIL mul8_after_done: done=%b ready=%b busy=%b p=%h want 0 1 0 %h",
                         done8, ready8, busy8, p8, prod);
            end
        end
    endtask

    task automatic mul3(input logic [2:0] ai, input logic [2:0] bi,
                        output logic [5:0] prod, output int lat);
        a3 = ai; b3 = bi; start3 = 1'b1;
        @(posedge clk); @(negedge clk);
        start3 = 1'b0;
        lat = -1;
        prod = 'x;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); @(negedge clk);
            if (done3) begin
                lat = n;
                break;
            end
        end
        prod = p3;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
            failures++;
            $display("FAIL reset8: ready=%b busy=%b done=%b p=%h want 1 0 0 0000",
                     ready8, busy8, done8, p8);
        end
        checks++;
        if (ready3 !== 1'b1 || busy3 !== 1'b0 || done3 !== 1'b0 || p3 !== 6'h0) begin
            failures++;
            $display("FAIL reset3: ready=%b busy=%b done=%b p=%h want 1 0 0 00",
                     ready3, busy3, done3, p3);
        end
        rst = 1'b0;
    endtask

    task automatic test_exhaustive3();
        logic [5:0] prod, exp_p;
        int lat;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                mul3(3'(i), 3'(j), prod, lat);
                exp_p = 6'(i * j);
                checks++;
                if (prod !== exp_p || lat != 3) begin
                    failures++;
                    $display("FAIL exh3 %0d*%0d: p=%h lat=%0d want p=%h lat=3",
                             i, j, prod, lat, exp_p);
                end
            end
        end
    endtask

    task automatic test_max_operands();
        logic [15:0] prod;
        int lat;
        mul8(8'hFF, 8'hFF, 1'b0, prod, lat);
        checks++;
        if (prod !== 16'hFE01 || lat != 8) begin
            failures++;
            $display("FAIL ffxff: p=%h lat=%0d want p=fe01 lat=8", prod, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prod;
        int lat;
        mul8(8'h00, 8'hA5, 1'b0, prod, lat);
        checks++;
        if (prod !== 16'h0000 || lat != 8) begin
            failures++;
            $display("FAIL b2b_first: p=%h lat=%0d want p=0000 lat=8", prod, lat);
        end
        mul8(8'h01, 8'hA5, 1'b0, prod, lat);
        checks++;
        if (prod !== 16'h00A5 || lat != 8) begin
            failures++;
            $display("FAIL b2b_second: p=%h lat=%0d want p=00a5 lat=8", prod, lat);
        end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        a8 = 8'h03; b8 = 8'h05; sgn8 = 1'b0; start8 = 1'b1;
        // start stays high from the accepting edge through the DONE->IDLE edge
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); @(negedge clk);
            if (done8) dones++;
            a8 = 8'($urandom); b8 = 8'($urandom);
        end
        start8 = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); @(negedge clk);
            if (done8) dones++;
        end
        checks++;
        if (dones != 1 || p8 !== 16'h000F || ready8 !== 1'b1) begin
            failures++;
            $display("FAIL busy_start: dones=%0d p=%h ready=%b want 1 000f 1", dones, p8, ready8);
        end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] prod;
        int lat;
        int dones = 0;
        a8 = 8'h12; b8 = 8'h34; sgn8 = 1'b0; start8 = 1'b1;
        @(posedge clk); @(negedge clk);
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
            failures++;
            $display("FAIL midrun_rst: ready=%b busy=%b done=%b p=%h want 1 0 0 0000",
                     ready8, busy8, done8, p8);
        end
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); @(negedge clk);
            if (done8) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL midrun_nodone: dones=%0d want 0", dones);
        end
        mul8(8'h12, 8'h34, 1'b0, prod, lat);
        checks++;
        if (prod !== 16'h03A8 || lat != 8) begin
            failures++;
            $display("FAIL midrun_fresh: p=%h lat=%0d want p=03a8 lat=8", prod, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] prod, exp_p;
        logic [7:0] x, y;
        logic s;
        int lat;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
`ifdef SIGNED_MODE_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            exp_p = ref8(x, y, s);
            mul8(x, y, s, prod, lat);
            checks++;
            if (prod !== exp_p || lat != 8) begin
                failures++;
                $display("FAIL rand %h*%h s=%b: p=%h lat=%0d want p=%h lat=8",
                         x, y, s, prod, lat, exp_p);
            end
        end
    endtask

`ifdef SIGNED_MODE_EN
    task automatic test_signed();
        logic [7:0]  xs [3] = '{8'hFD, 8'h80, 8'h80};
        logic [7:0]  ys [3] = '{8'h05, 8'h80, 8'hFF};
        logic [15:0] es [3] = '{16'hFFF1, 16'h4000, 16'h0080};
        logic [15:0] prod;
        int lat;
        for (int i = 0; i < 3; i++) begin
            mul8(xs[i], ys[i], 1'b1, prod, lat);
            checks++;
            if (prod !== es[i] || lat != 8) begin
                failures++;
                $display("FAIL signed %h*%h: p=%h lat=%0d want p=%h lat=8",
                         xs[i], ys[i], prod, lat, es[i]);
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        @(negedge clk);
        test_exhaustive3();
        test_max_operands();
        test_back_to_back();
        test_start_while_busy();
        test_reset_midrun();
`ifdef SIGNED_MODE_EN
        test_signed();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
